// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller and its ALU decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0001;
    localparam logic [3:0] ALUC_AND = 4'b0010;
    localparam logic [3:0] ALUC_OR  = 4'b0011;
    localparam logic [3:0] ALUC_SLT = 4'b0101;

    localparam logic [1:0] EXT_I = 2'b00;
    localparam logic [1:0] EXT_S = 2'b01;
    localparam logic [1:0] EXT_B = 2'b10;
    localparam logic [1:0] EXT_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    function automatic logic [1:0] ext_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return EXT_S;
            OP_BEQ:  return EXT_B;
            OP_JAL:  return EXT_J;
            default: return EXT_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the controller's ALUOp plus instruction function fields to an ALU control code.
module alu_decoder
    import mc_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  aluop_t            aluop,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              op5,
    output logic [ALUC_W-1:0] aluc
);

    logic [3:0] code;

    always_comb begin
        code = ALUC_ADD;
        case (aluop)
            ALUOP_SUB: code = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for register-register ops; addi ignores it
                    3'b000:  code = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  code = ALUC_SLT;
                    3'b110:  code = ALUC_OR;
                    3'b111:  code = ALUC_AND;
                    default: code = ALUC_ADD;
                endcase
            end
            default: code = ALUC_ADD;
        endcase
    end

    assign aluc = ALUC_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: state register, next-state logic and combinational output decode.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALUC_W        = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              PCwe,
    output logic              IRwe,
    output logic              AdrSrc,
    output logic              Regwe,
    output logic              DMemwe,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [ALUC_W-1:0] ALUc,
    output logic [1:0]        Extendc,
    output logic              illegal,
    output logic [3:0]        state
);

    state_t cur, nxt;
    aluop_t aluop;
    logic   mr;
    logic   set_ill;

    assign mr = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        nxt     = cur;
        set_ill = 1'b0;
        case (cur)
            FETCH:    if (mr) nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECR;
                    OP_I:         nxt = EXECI;
                    OP_BEQ:       nxt = BEQ;
                    OP_JAL:       nxt = JAL;
                    default: begin
                        nxt     = FETCH;
                        set_ill = 1'b1;
                    end
                endcase
            end
            MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mr) nxt = MEMWB;
            MEMWB:    nxt = FETCH;
            MEMWRITE: if (mr) nxt = FETCH;
            EXECR:    nxt = ALUWB;
            EXECI:    nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            JAL:      nxt = ALUWB;
            BEQ:      nxt = FETCH;
            default:  nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= FETCH;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (set_ill) illegal <= 1'b1;
        end
    end

    always_comb begin
        PCwe      = 1'b0;
        IRwe      = 1'b0;
        AdrSrc    = 1'b0;
        Regwe     = 1'b0;
        DMemwe    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        aluop     = ALUOP_ADD;
        case (cur)
            FETCH: begin
                IRwe      = mr;
                PCwe      = mr;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_RDATA;
                Regwe     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                DMemwe = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB:    Regwe = 1'b1;
            JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCwe    = 1'b1;
            end
            BEQ: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_SUB;
                PCwe    = Zero;
            end
            default: ;
        endcase
        // Write enables must not leak while reset holds, even mid-instruction
        if (reset) begin
            PCwe   = 1'b0;
            IRwe   = 1'b0;
            Regwe  = 1'b0;
            DMemwe = 1'b0;
        end
    end

    alu_decoder #(.ALUC_W(ALUC_W)) u_alu_decoder (
        .aluop    (aluop),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .op5      (op[5]),
        .aluc     (ALUc)
    );

    assign Extendc = ext_sel(op);
    assign state   = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expected controls, a monitor pops and compares.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, funct7b5, Zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;

    logic       pcwe1, irwe1, adr1, regwe1, dmwe1, ill1;
    logic [1:0] sa1, sb1, rs1, ext1;
    logic [3:0] aluc1, st1;

    logic       pcwe2, irwe2, adr2, regwe2, dmwe2, ill2;
    logic [1:0] sa2, sb2, rs2, ext2;
    logic [4:0] aluc2;
    logic [3:0] st2;

    multicycle_controller #(.ALUC_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready),
        .PCwe(pcwe1), .IRwe(irwe1), .AdrSrc(adr1), .Regwe(regwe1), .DMemwe(dmwe1),
        .ALUSrcA(sa1), .ALUSrcB(sb1), .ResultSrc(rs1), .ALUc(aluc1), .Extendc(ext1),
        .illegal(ill1), .state(st1)
    );

    multicycle_controller #(.ALUC_W(5), .MEM_HANDSHAKE(1'b0)) dut_nohs (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(1'b0),
        .PCwe(pcwe2), .IRwe(irwe2), .AdrSrc(adr2), .Regwe(regwe2), .DMemwe(dmwe2),
        .ALUSrcA(sa2), .ALUSrcB(sb2), .ResultSrc(rs2), .ALUc(aluc2), .Extendc(ext2),
        .illegal(ill2), .state(st2)
    );

    typedef struct {
        string      nm;
        logic       chk2;
        logic [3:0] st;
        logic [4:0] we;   // {PCwe, IRwe, AdrSrc, Regwe, DMemwe}
        logic [1:0] sa, sb, rs;
        logic [3:0] aluc;
        logic [1:0] ext;
        logic       ill;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    event chk_now;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or chk_now);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.nm, ".state"},   32'(st1), 32'(e.st));
                chk({e.nm, ".we"},      32'({pcwe1, irwe1, adr1, regwe1, dmwe1}), 32'(e.we));
                chk({e.nm, ".srca"},    32'(sa1), 32'(e.sa));
                chk({e.nm, ".srcb"},    32'(sb1), 32'(e.sb));
                chk({e.nm, ".result"},  32'(rs1), 32'(e.rs));
                chk({e.nm, ".aluc"},    32'(aluc1), 32'(e.aluc));
                chk({e.nm, ".ext"},     32'(ext1), 32'(e.ext));
                chk({e.nm, ".illegal"}, 32'(ill1), 32'(e.ill));
                if (e.chk2) begin
                    chk({e.nm, ".nohs.state"},   32'(st2), 32'(e.st));
                    chk({e.nm, ".nohs.we"},      32'({pcwe2, irwe2, adr2, regwe2, dmwe2}), 32'(e.we));
                    chk({e.nm, ".nohs.aluc"},    32'(aluc2), 32'(e.aluc));
                    chk({e.nm, ".nohs.illegal"}, 32'(ill2), 32'(e.ill));
                end
            end
        end
    end

    task automatic push(input string nm, input logic c2, input logic [3:0] st, input logic [4:0] we,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                        input logic [3:0] al, input logic [1:0] ex, input logic il);
        exp_t x;
        x.nm = nm; x.chk2 = c2; x.st = st; x.we = we; x.sa = sa; x.sb = sb; x.rs = rs;
        x.aluc = al; x.ext = ex; x.ill = il;
        sbq.push_back(x);
    endtask

    task automatic step(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input logic mr, input logic c2, input logic [3:0] st,
                        input logic [4:0] we, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] rs, input logic [3:0] al, input logic [1:0] ex,
                        input logic il);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr;
        push(nm, c2, st, we, sa, sb, rs, al, ex, il);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op = SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // sw stalled in MEMWRITE, then reset mid-cycle
        step("sw_fetch",  SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b01, 0);
        step("sw_decode", SW, 3'b010, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b01, 0);
        step("sw_memadr", SW, 3'b010, 0, 0, 1, 0, 4'd2, 5'b00000, 2'b10, 2'b01, 2'b00, 4'h0, 2'b01, 0);
        mem_ready = 1'b0;
        push("sw_wait", 0, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 4'h0, 2'b01, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        push("rst_async", 0, 4'd0, 5'b00000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b01, 0);
        #1;
        ->chk_now;
        @(posedge clk);
        #1;
        step("rst_hold",  SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b00000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b01, 0);
        reset = 1'b0;
        step("rel_fetch", SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b01, 0);
        do_reset();

        // lw without waits
        step("lw_fetch",  LW, 3'b010, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("lw_decode", LW, 3'b010, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("lw_memadr", LW, 3'b010, 0, 0, 1, 1, 4'd2, 5'b00000, 2'b10, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("lw_memrd",  LW, 3'b010, 0, 0, 1, 1, 4'd3, 5'b00100, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        step("lw_memwb",  LW, 3'b010, 0, 0, 1, 1, 4'd4, 5'b00010, 2'b00, 2'b00, 2'b01, 4'h0, 2'b00, 0);

        // sw with three wait cycles in MEMWRITE
        step("sw2_fetch",  SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b01, 0);
        step("sw2_decode", SW, 3'b010, 0, 0, 1, 0, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b01, 0);
        step("sw2_memadr", SW, 3'b010, 0, 0, 1, 0, 4'd2, 5'b00000, 2'b10, 2'b01, 2'b00, 4'h0, 2'b01, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("sw2_wait%0d", i), SW, 3'b010, 0, 0, 0, 0, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 4'h0, 2'b01, 0);
        step("sw2_done",   SW, 3'b010, 0, 0, 1, 0, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 4'h0, 2'b01, 0);
        step("sw2_back",   SW, 3'b010, 0, 0, 1, 0, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b01, 0);
        do_reset();

        // R sub
        step("rsub_fetch",  RT, 3'b000, 1, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("rsub_decode", RT, 3'b000, 1, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("rsub_exec",   RT, 3'b000, 1, 0, 1, 1, 4'd6, 5'b00000, 2'b10, 2'b00, 2'b00, 4'h1, 2'b00, 0);
        step("rsub_wb",     RT, 3'b000, 1, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        // addi with funct7b5 set stays add
        step("addi_fetch",  IT, 3'b000, 1, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("addi_decode", IT, 3'b000, 1, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("addi_exec",   IT, 3'b000, 1, 0, 1, 1, 4'd7, 5'b00000, 2'b10, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("addi_wb",     IT, 3'b000, 1, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        // andi, R or, R slt, R funct3=001 (falls back to add)
        step("andi_fetch",  IT, 3'b111, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("andi_decode", IT, 3'b111, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("andi_exec",   IT, 3'b111, 0, 0, 1, 1, 4'd7, 5'b00000, 2'b10, 2'b01, 2'b00, 4'h2, 2'b00, 0);
        step("andi_wb",     IT, 3'b111, 0, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        step("ror_fetch",   RT, 3'b110, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("ror_decode",  RT, 3'b110, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("ror_exec",    RT, 3'b110, 0, 0, 1, 1, 4'd6, 5'b00000, 2'b10, 2'b00, 2'b00, 4'h3, 2'b00, 0);
        step("ror_wb",      RT, 3'b110, 0, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        step("rslt_fetch",  RT, 3'b010, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("rslt_decode", RT, 3'b010, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("rslt_exec",   RT, 3'b010, 0, 0, 1, 1, 4'd6, 5'b00000, 2'b10, 2'b00, 2'b00, 4'h5, 2'b00, 0);
        step("rslt_wb",     RT, 3'b010, 0, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        step("rsll_fetch",  RT, 3'b001, 1, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("rsll_decode", RT, 3'b001, 1, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("rsll_exec",   RT, 3'b001, 1, 0, 1, 1, 4'd6, 5'b00000, 2'b10, 2'b00, 2'b00, 4'h0, 2'b00, 0);
        step("rsll_wb",     RT, 3'b001, 1, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 0);

        // beq taken and not taken
        step("beqt_fetch",  BQ, 3'b000, 0, 1, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b10, 0);
        step("beqt_decode", BQ, 3'b000, 0, 1, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b10, 0);
        step("beqt_beq",    BQ, 3'b000, 0, 1, 1, 1, 4'd9, 5'b10000, 2'b10, 2'b00, 2'b00, 4'h1, 2'b10, 0);
        step("beqn_fetch",  BQ, 3'b000, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b10, 0);
        step("beqn_decode", BQ, 3'b000, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b10, 0);
        step("beqn_beq",    BQ, 3'b000, 0, 0, 1, 1, 4'd9, 5'b00000, 2'b10, 2'b00, 2'b00, 4'h1, 2'b10, 0);

        // jal
        step("jal_fetch",  JL, 3'b000, 0, 0, 1, 1, 4'd0,  5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b11, 0);
        step("jal_decode", JL, 3'b000, 0, 0, 1, 1, 4'd1,  5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b11, 0);
        step("jal_jal",    JL, 3'b000, 0, 0, 1, 1, 4'd10, 5'b10000, 2'b01, 2'b10, 2'b00, 4'h0, 2'b11, 0);
        step("jal_wb",     JL, 3'b000, 0, 0, 1, 1, 4'd8,  5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b11, 0);

        // illegal opcode, then a valid add keeps the sticky flag
        step("ill_fetch",  BAD, 3'b000, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 0);
        step("ill_decode", BAD, 3'b000, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 0);
        step("add_fetch",  RT,  3'b000, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 1);
        step("add_decode", RT,  3'b000, 0, 0, 1, 1, 4'd1, 5'b00000, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 1);
        step("add_exec",   RT,  3'b000, 0, 0, 1, 1, 4'd6, 5'b00000, 2'b10, 2'b00, 2'b00, 4'h0, 2'b00, 1);
        step("add_wb",     RT,  3'b000, 0, 0, 1, 1, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1);
        step("add_back",   RT,  3'b000, 0, 0, 1, 1, 4'd0, 5'b11000, 2'b00, 2'b10, 2'b10, 4'h0, 2'b00, 1);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle RV32I control unit: the successor to the single-cycle main decoder. A state register sequences each instruction over 3–5 cycles and drives the shared-memory datapath's write enables, mux selects, ALU control and immediate-extend select. An optional memory-ready handshake stalls fetch, load and store for variable-latency memory. It sits beside the multicycle datapath, receiving opcode fields from the instruction register and the ALU Zero flag.

## Interface
- ALUC_W, 4: width of ALUc. Encodings are zero-extended to this width; must be ≥4.
- MEM_HANDSHAKE, 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  instruction[6:0] from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCwe  out  1  PC write enable.
- IRwe  out  1  instruction/old-PC register write enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- Regwe  out  1  register file write enable.
- DMemwe  out  1  memory write enable.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUc  out  ALUC_W  ALU operation.
- Extendc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- illegal  out  1  sticky flag set by an unsupported opcode.
- state  out  4  current state (debug).

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Unlisted outputs are 0 in every state; ALUc defaults to add.

States, with outputs and transitions:
- FETCH: AdrSrc=0, IRwe=mem_ready, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCwe=mem_ready. Goes to DECODE when mem_ready, otherwise stays.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut).
  - lw/sw → MEMADR; R → EXECR; I → EXECI; beq → BEQ; jal → JAL.
  - Any other opcode → FETCH and set illegal.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: AdrSrc=1. Goes to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, Regwe=1. → FETCH.
- MEMWRITE: AdrSrc=1, DMemwe=1, held high for every wait cycle. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. → ALUWB.
- ALUWB: ResultSrc=00, Regwe=1. → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCwe=1. → ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCwe=Zero. → FETCH.

ALU decode:
- ALUOp add → 0000; sub → 0001.
- ALUOp funct, by funct3:
  - 000 → sub (0001) iff op[5] & funct7b5, otherwise add (0000).
  - 010 → slt (0101).
  - 110 → or (0011).
  - 111 → and (0010).
  - Any other → add (0000).
- Extendc is decoded from op in every state: lw/I → 00, sw → 01, beq → 10, jal → 11, other → 00.

## Timing
- State register updates on the rising edge of clk. All outputs are combinational from state, op, funct3, funct7b5, Zero and mem_ready.
- Reset:
  - Asynchronous; state ← FETCH, illegal ← 0.
  - While reset is high, PCwe, IRwe, Regwe and DMemwe are forced to 0. Mux selects and ALUc show the FETCH values.
  - FETCH proceeds on the first edge after deassertion.
  - Reset asserted mid-instruction (including during a MEMWRITE wait) drops DMemwe immediately and abandons the instruction.
- Cycles per instruction with zero wait: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Each wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- With MEM_HANDSHAKE=0, no waits occur.
- illegal stays set until reset.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.

## Structure
- Shared package `mc_pkg` holds:
  - state enum (4 bits: FETCH=0 … JAL=10);
  - ALUOp enum (add/sub/funct);
  - opcode constants;
  - ALUc, Extendc, ALUSrcA/B and ResultSrc constants.
- Sub-module `alu_decoder`: combinational ALUOp, funct3, funct7b5, op[5] → ALUc.
- The top module holds the state register, next-state logic and output decode.

## Test plan
- Reset asserted mid-MEMWRITE, then released: DMemwe drops in the same cycle, state=0, illegal=0. The first edge after release shows FETCH outputs with PCwe=1 (mem_ready=1).
- lw, mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. Regwe=1 only in MEMWB, with ResultSrc=01.
- sw with mem_ready low for 3 cycles in MEMWRITE: DMemwe=1 for 4 consecutive cycles, then FETCH.
- Arithmetic decode:
  - R sub (funct3=000, funct7b5=1) → ALUc=0001 in EXECR.
  - I addi with funct7b5=1 → ALUc=0000.
  - funct3=111 → 0010.
- beq: Zero=1 → PCwe=1 in BEQ; Zero=0 → PCwe=0. Both return to FETCH after 3 cycles.
- op=1111111: DECODE → FETCH and illegal=1; illegal stays 1 through a following valid add. With MEM_HANDSHAKE=0 and mem_ready tied 0, fetch never stalls.
